// File: rtl/vga_rx_monitor_if.sv
// Monitored VGA link as seen on the wire: pixel clock, syncs and colour.
// The source drives it through master; the monitor samples it through slave.
interface vga_rx_monitor_if;
    logic       vga_clk;
    logic       vga_hs;
    logic       vga_vs;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;

    modport master (output vga_clk, vga_hs, vga_vs, vga_r, vga_g, vga_b);
    modport slave  (input  vga_clk, vga_hs, vga_vs, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_rx_monitor.sv
// Passive VGA timing monitor: measures line/frame geometry in the CLOCK_50 domain,
// locks onto the expected format, flags timing errors and captures one probed pixel.
module vga_rx_monitor #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int H_SYNC  = 97,
    parameter int TIMEOUT = 64
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    vga_rx_monitor_if.slave link,
    input  logic [9:0]      probe_x,
    input  logic [9:0]      probe_y,
    input  logic            clear_err,
    output logic            locked,
    output logic [10:0]     h_cnt,
    output logic [9:0]      v_cnt,
    output logic [10:0]     line_len,
    output logic [9:0]      frame_lines,
    output logic [9:0]      hs_width,
    output logic [15:0]     frame_count,
    output logic            err_line,
    output logic            err_frame,
    output logic            clk_lost,
    output logic [23:0]     probe_rgb,
    output logic            probe_valid,
    output logic [1:0]      state_dbg,
    output logic            hs_width_nominal
);
    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [26:0]   sync1, sync2;
    logic          clk_d, clk_s, hs_s, vs_s;
    logic [23:0]   rgb_s;
    logic          pix_tick, hs_prev, vs_prev, hs_rise, hs_fall, vs_rise;
    logic [10:0]   h_inc, h_next;
    logic [9:0]    v_inc, v_next, hs_wcnt;
    logic          line_bad, frame_short, timeout_hit, probe_hit;
    logic [TW-1:0] tcnt;
    state_t        state, state_next;
    logic          lines_ok, lines_ok_next, exempt, exempt_next;
    logic          frame_bad, frame_bad_next, prev_bad, prev_bad_next, bad_now;
    logic          set_err_line, set_err_frame, count_frame;

    // All link bits share one two-stage synchroniser so they stay aligned.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            clk_d <= 1'b0;
        end else begin
            sync1 <= {link.vga_clk, link.vga_hs, link.vga_vs, link.vga_r, link.vga_g, link.vga_b};
            sync2 <= sync1;
            clk_d <= sync2[26];
        end
    end

    assign clk_s    = sync2[26];
    assign hs_s     = sync2[25];
    assign vs_s     = sync2[24];
    assign rgb_s    = sync2[23:0];
    assign pix_tick = clk_s & ~clk_d;
    assign hs_rise  = pix_tick & hs_s & ~hs_prev;
    assign hs_fall  = pix_tick & ~hs_s & hs_prev;
    assign vs_rise  = pix_tick & vs_s & ~vs_prev;

    assign h_inc       = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
    assign v_inc       = (v_cnt == 10'h3FF) ? v_cnt : v_cnt + 10'd1;
    assign h_next      = hs_rise ? 11'd0 : h_inc;
    assign v_next      = vs_rise ? 10'd0 : (hs_rise ? v_inc : v_cnt);
    assign line_bad    = hs_rise && (h_inc != 11'(H_TOTAL));
    assign frame_short = (v_inc != 10'(V_TOTAL));
    assign timeout_hit = !pix_tick && (tcnt == TW'(TIMEOUT - 1));
    assign probe_hit   = pix_tick && (state == LOCKED) &&
                         (h_next == {1'b0, probe_x}) && (v_next == probe_y);

    // A coincident HS rise at the VS tick closes the last line of the ending frame.
    always_comb begin
        state_next     = state;
        lines_ok_next  = lines_ok;
        exempt_next    = exempt;
        frame_bad_next = frame_bad;
        prev_bad_next  = prev_bad;
        bad_now        = 1'b0;
        set_err_line   = 1'b0;
        set_err_frame  = 1'b0;
        count_frame    = 1'b0;
        if (timeout_hit) begin
            state_next = SEARCH;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state_next    = MEASURE;
                        lines_ok_next = 1'b1;
                        exempt_next   = 1'b1;
                    end
                end
                MEASURE: begin
                    if (vs_rise) begin
                        if (lines_ok && !(line_bad && !exempt) && !frame_short) begin
                            state_next     = LOCKED;
                            frame_bad_next = 1'b0;
                            prev_bad_next  = 1'b0;
                        end else begin
                            lines_ok_next = 1'b1;
                            exempt_next   = 1'b1;
                        end
                    end else if (hs_rise) begin
                        if (exempt) exempt_next = 1'b0;
                        else if (line_bad) lines_ok_next = 1'b0;
                    end
                end
                LOCKED: begin
                    set_err_line = line_bad;
                    if (vs_rise) begin
                        count_frame    = 1'b1;
                        set_err_frame  = frame_short;
                        bad_now        = frame_bad | line_bad | frame_short;
                        if (bad_now && prev_bad) state_next = SEARCH;
                        prev_bad_next  = bad_now;
                        frame_bad_next = 1'b0;
                    end else if (line_bad) begin
                        frame_bad_next = 1'b1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            lines_ok  <= 1'b0;
            exempt    <= 1'b0;
            frame_bad <= 1'b0;
            prev_bad  <= 1'b0;
        end else begin
            state     <= state_next;
            lines_ok  <= lines_ok_next;
            exempt    <= exempt_next;
            frame_bad <= frame_bad_next;
            prev_bad  <= prev_bad_next;
        end
    end

    // probe_valid is a one-cycle strobe with no ready: take probe_rgb while it is high;
    // probe_rgb then holds until the next capture.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            hs_width    <= '0;
            hs_wcnt     <= '0;
            tcnt        <= '0;
            frame_count <= '0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            clk_lost    <= 1'b0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            if (pix_tick) tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;

            if (timeout_hit) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (pix_tick) begin
                hs_prev <= hs_s;
                vs_prev <= vs_s;
                h_cnt   <= h_next;
                v_cnt   <= v_next;
                if (hs_rise) line_len <= h_inc;
                if (vs_rise) frame_lines <= v_inc;
                if (hs_fall) begin
                    hs_width <= hs_wcnt;
                    hs_wcnt  <= '0;
                end else if (hs_s && hs_wcnt != 10'h3FF) begin
                    hs_wcnt <= hs_wcnt + 10'd1;
                end
            end

            if (count_frame) frame_count <= frame_count + 16'd1;

            if (set_err_line) err_line <= 1'b1;
            else if (clear_err) err_line <= 1'b0;
            if (set_err_frame) err_frame <= 1'b1;
            else if (clear_err) err_frame <= 1'b0;
            if (timeout_hit) clk_lost <= 1'b1;
            else if (clear_err) clk_lost <= 1'b0;

            probe_valid <= probe_hit;
            if (probe_hit) probe_rgb <= rgb_s;
        end
    end

    assign locked           = (state == LOCKED);
    assign state_dbg        = state;
    assign hs_width_nominal = (hs_width == 10'(H_SYNC));
endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- CLOCK_50, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- vga_clk, in, 1: pixel clock of monitored link, nominally CLOCK_50/2.
- vga_hs, in, 1: horizontal sync, active-high pulse.
- vga_vs, in, 1: vertical sync, active-high pulse.
- vga_r / vga_g / vga_b, in, 8 each: pixel colour.
- probe_x, in, 10: raw horizontal counter value to capture.
- probe_y, in, 10: raw line counter value to capture.
- clear_err, in, 1: clears sticky error flags.
- locked, out, 1: timing matches expected format.
- h_cnt, out, 11: pixel ticks since last HS rise.
- v_cnt, out, 10: lines since last VS rise.
- line_len, out, 11: last measured line length in ticks.
- frame_lines, out, 10: last measured lines per frame.
- hs_width, out, 10: last HS high width in ticks.
- frame_count, out, 16: frames counted while locked.
- err_line, out, 1: sticky line-length mismatch.
- err_frame, out, 1: sticky line-count mismatch.
- clk_lost, out, 1: sticky pixel-clock timeout.
- probe_rgb, out, 24: captured pixel, packed {r,g,b}.
- probe_valid, out, 1: one-cycle capture strobe.

REQ-002 SHALL have these parameters (name, default, meaning):
- H_TOTAL, 800: expected ticks per line.
- V_TOTAL, 525: expected lines per frame.
- H_SYNC, 97: expected HS high width in ticks.
- TIMEOUT, 64: CLOCK_50 cycles without a tick before the clock is declared lost.

Function
REQ-003 Each link input SHALL pass through a 2-flop synchroniser in the CLOCK_50 domain; all inputs share the same delay.
REQ-004 pix_tick SHALL be a one-cycle pulse on a synchronised vga_clk 0->1 transition; all sampling and counting below occurs only on pix_tick.
REQ-005 HS rise SHALL mean synced hs=1 at this tick and 0 at the previous tick; VS rise is defined the same way.
REQ-006 h_cnt SHALL behave as follows:
- On HS rise: h_cnt <= 0, and line_len <= h_cnt+1.
- Otherwise: h_cnt <= h_cnt+1, saturating at 2047 (line_len saturates too).
REQ-007 While HS is high, an internal width counter SHALL increment; on HS fall, hs_width <= count (saturating at 1023) and the counter clears.
REQ-008 v_cnt SHALL increment on each HS rise, saturating at 1023.
REQ-009 On VS rise, v_cnt <= 0 and frame_lines <= v_cnt+1 (saturating); this takes priority over the REQ-008 increment at the same tick.
REQ-010 The FSM SHALL have states SEARCH, MEASURE, LOCKED.
REQ-011 SEARCH -> MEASURE on the first VS rise.
REQ-012 MEASURE SHALL behave as follows:
- Track whether every HS rise in the frame gave line_len == H_TOTAL (first line after VS exempt).
- At the next VS rise: -> LOCKED if all lines matched and v_cnt+1 == V_TOTAL; otherwise stay in MEASURE and restart the check.
REQ-013 In LOCKED:
- Any line mismatch sets err_line.
- A VS rise with v_cnt+1 != V_TOTAL sets err_frame.
- A frame containing any mismatch counts as bad.
- Two consecutive bad frames -> SEARCH.
REQ-014 locked SHALL be 1 exactly while the state is LOCKED.
REQ-015 frame_count SHALL increment by 1 on each VS rise that occurs while in LOCKED, wrapping 65535 -> 0.
REQ-016 The timeout counter SHALL clear on each pix_tick; on reaching TIMEOUT, set clk_lost, go to SEARCH, and clear h_cnt and v_cnt.
REQ-017 When locked and on a tick where h_cnt == probe_x and v_cnt == probe_y (compared after this tick's update), probe_rgb SHALL latch the synchronised RGB and probe_valid SHALL pulse high on the next CLOCK_50 cycle for exactly 1 cycle.
REQ-018 clear_err SHALL clear err_line, err_frame and clk_lost in the next cycle; if a new error occurs in the same cycle, the set wins.
REQ-019 hs_width SHALL be informational only; a mismatch against H_SYNC sets no flag.

Reset
REQ-020 Asserting reset SHALL immediately force:
- state = SEARCH;
- all counters, measured values, flags, probe_rgb and probe_valid = 0;
- synchroniser flops = 0.
REQ-021 Reset asserted mid-frame SHALL discard all measurement; after release, relock requires a VS rise followed by one full good frame.

Verification
REQ-022 Ideal 800x525 source with HS high 97 ticks and VS high 3 lines -> locked=1 at the second VS rise; line_len=800, frame_lines=525, hs_width=97; no error flags.
REQ-023 While locked, one line of 799 ticks -> err_line=1 and locked stays 1; two consecutive frames each with a short line -> locked=0 and state SEARCH.
REQ-024 While locked, a frame of 524 lines -> err_frame=1 and frame_lines=524; clear_err pulse -> all flags 0 the next cycle.
REQ-025 While locked, vga_clk stopped for 64 CLOCK_50 cycles -> clk_lost=1, locked=0, h_cnt=0, v_cnt=0.
REQ-026 With probe_x=200, probe_y=100, source pixel there = 0x9933FF, all others 0 -> probe_valid pulses once per frame with probe_rgb=0x9933FF.
REQ-027 frame_count preset near wrap (run 65536 locked frames, or use a forced-state check) -> 65535 -> 0 on the next VS rise.
